// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin accepts two producers' register writes into an in-order
// FIFO whose head drives the register file write port; exports a per-register pending mask.
module writeback_arbiter #(
    parameter int DTYPE = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in0_val,
    output logic                       in0_rdy,
    input  logic [AW-1:0]              in0_addr,
    input  logic [DTYPE-1:0]           in0_data,
    input  logic                       in1_val,
    output logic                       in1_rdy,
    input  logic [AW-1:0]              in1_addr,
    input  logic [DTYPE-1:0]           in1_data,
    input  logic                       drain_en,
    output logic                       wr_call,
    output logic [AW-1:0]              wr_addr,
    output logic [DTYPE-1:0]           wr_data,
    output logic [NREGS-1:0]           pending,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             prio_q, prio_d;

    logic [AW-1:0]    entry_addr_q [DEPTH];
    logic [DTYPE-1:0] entry_data_q [DEPTH];

    logic             full;
    logic             grant1;
    logic             enq;
    logic             deq;
    logic [AW-1:0]    enq_addr;
    logic [DTYPE-1:0] enq_data;
    logic [PW-1:0]    offset;
    logic [NREGS-1:0] pending_v;

    always_comb begin
        full     = (count_q == FULL_CNT);
        // Priority pointer only matters when both producers contend.
        grant1   = in1_val & (~in0_val | prio_q);
        in0_rdy  = reset & ~full & in0_val & ~grant1;
        in1_rdy  = reset & ~full & grant1;
        enq      = in0_rdy | in1_rdy;
        enq_addr = grant1 ? in1_addr : in0_addr;
        enq_data = grant1 ? in1_data : in0_data;

        deq      = (count_q != '0) & drain_en;
        wr_call  = deq;
        wr_addr  = '0;
        wr_data  = '0;
        if (count_q != '0) begin
            wr_addr = entry_addr_q[head_q];
            wr_data = entry_data_q[head_q];
        end

        head_d  = deq ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CW'(1);
        end
        prio_d  = (in0_val & in1_val & enq) ? ~prio_q : prio_q;
    end

    // An entry is valid when its distance from head is below the occupancy.
    always_comb begin
        pending_v = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - head_q;
            if ({1'b0, offset} < count_q) begin
                pending_v[entry_addr_q[i]] = 1'b1;
            end
        end
        pending = pending_v;
        count   = count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            prio_q  <= prio_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entry_addr_q[tail_q] <= enq_addr;
            entry_data_q[tail_q] <= enq_data;
        end
    end

endmodule
